// File: rtl/systolic_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_buffer_ctrl_if
// Brief    : Control/address bundle between the output-buffer sequencer and
//            the array, buffer RAM and downstream consumer.
// Revision : 1.0
// ============================================================================
interface systolic_buffer_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] cfg_rows;
    logic                  s_valid;
    logic                  s_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    // Environment side: issues tiles, streams rows in, consumes rows out.
    modport master (
        output start,
        output cfg_rows,
        output s_valid,
        output m_ready,
        input  s_ready,
        input  we,
        input  wr_addr,
        input  rd_addr,
        input  m_valid,
        input  m_last,
        input  busy,
        input  done,
        input  cfg_err
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  cfg_rows,
        input  s_valid,
        input  m_ready,
        output s_ready,
        output we,
        output wr_addr,
        output rd_addr,
        output m_valid,
        output m_last,
        output busy,
        output done,
        output cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/systolic_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_buffer_ctrl
// Brief    : Fills the systolic-array output buffer with one tile of rows,
//            then drains it in order under valid/ready backpressure.
// Revision : 1.0
// ============================================================================
module systolic_buffer_ctrl #(
    parameter int DEPTH      = 543,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_buffer_ctrl_if.slave bus
);

    // One extra bit so a count equal to DEPTH compares correctly.
    localparam int                 c_cnt_w = ADDR_WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_zero  = '0;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fill  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [c_cnt_w-1:0]    r_rows;
    logic [c_cnt_w-1:0]    r_wr_ptr;
    logic [c_cnt_w-1:0]    r_issue_ptr;
    logic [ADDR_WIDTH-1:0] r_disp_addr;
    logic                  r_m_valid;
    logic                  r_done;
    logic                  r_cfg_err;

    logic w_cfg_ok;
    logic w_write;
    logic w_fill_end;
    logic w_stall;
    logic w_hs;
    logic w_last;
    logic w_issue;
    logic w_drain_end;

    assign w_cfg_ok    = (bus.cfg_rows != '0) && ({1'b0, bus.cfg_rows} <= c_depth);
    assign w_write     = (r_state == c_st_fill) && bus.s_valid;
    assign w_fill_end  = w_write && ((r_wr_ptr + c_one) == r_rows);
    assign w_stall     = r_m_valid && !bus.m_ready;
    assign w_hs        = r_m_valid && bus.m_ready;
    assign w_last      = r_m_valid && ({1'b0, r_disp_addr} == (r_rows - c_one));
    assign w_issue     = (r_state == c_st_drain) && !w_stall && (r_issue_ptr < r_rows);
    assign w_drain_end = (r_state == c_st_drain) && w_hs && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.start && w_cfg_ok) begin
                    w_next_state = c_st_fill;
                end
            end
            c_st_fill: begin
                if (w_fill_end) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_drain_end) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        bus.s_ready = (r_state == c_st_fill);
        bus.we      = w_write;
        bus.wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
        // Re-reading the shown row while stalled keeps RAM out_data stable.
        bus.rd_addr = w_stall ? r_disp_addr : r_issue_ptr[ADDR_WIDTH-1:0];
        bus.m_valid = r_m_valid;
        bus.m_last  = w_last;
        bus.busy    = (r_state != c_st_idle);
        bus.done    = r_done;
        bus.cfg_err = r_cfg_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows      <= c_zero;
            r_wr_ptr    <= c_zero;
            r_issue_ptr <= c_zero;
            r_disp_addr <= '0;
            r_m_valid   <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_done    <= w_drain_end;
            r_cfg_err <= (r_state == c_st_idle) && bus.start && !w_cfg_ok;
            case (r_state)
                c_st_idle: begin
                    r_m_valid <= 1'b0;
                    if (bus.start) begin
                        r_rows      <= {1'b0, bus.cfg_rows};
                        r_wr_ptr    <= c_zero;
                        r_issue_ptr <= c_zero;
                        r_disp_addr <= '0;
                    end
                end
                c_st_fill: begin
                    if (w_fill_end) begin
                        r_wr_ptr <= c_zero;
                    end else if (w_write) begin
                        r_wr_ptr <= r_wr_ptr + c_one;
                    end
                end
                c_st_drain: begin
                    if (w_drain_end) begin
                        r_issue_ptr <= c_zero;
                        r_disp_addr <= '0;
                        r_m_valid   <= 1'b0;
                    end else if (w_issue) begin
                        r_issue_ptr <= r_issue_ptr + c_one;
                        r_disp_addr <= r_issue_ptr[ADDR_WIDTH-1:0];
                        r_m_valid   <= 1'b1;
                    end else if (!w_stall) begin
                        r_m_valid <= 1'b0;
                    end
                end
                default: r_m_valid <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_buffer_ctrl
// Brief    : Directed self-checking bench with a 1-cycle-latency RAM model.
// Revision : 1.0
// ============================================================================
module tb_systolic_buffer_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    systolic_buffer_ctrl_if #(.ADDR_WIDTH(10)) bus ();

    systolic_buffer_ctrl #(
        .DEPTH      (543),
        .ADDR_WIDTH (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer RAM model: row tag = {tile id, row index}.
    logic [15:0] mem [0:1023];
    logic [15:0] ram_q;
    logic [15:0] s_data;
    always @(posedge clk) begin
        if (bus.we) mem[bus.wr_addr] <= s_data;
        ram_q <= mem[bus.rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
        chk({tag, "_we"},      32'(bus.we),      0);
        chk({tag, "_m_valid"}, 32'(bus.m_valid), 0);
        chk({tag, "_m_last"},  32'(bus.m_last),  0);
        chk({tag, "_busy"},    32'(bus.busy),    0);
        chk({tag, "_done"},    32'(bus.done),    0);
        chk({tag, "_cfg_err"}, 32'(bus.cfg_err), 0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    endtask

    task automatic do_start(input int rows);
        bus.start    = 1'b1;
        bus.cfg_rows = 10'(rows);
        @(negedge clk);
        bus.start    = 1'b0;
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] pat, input int len,
                        input int poke, input logic [5:0] tile);
        int cnt = 0;
        int k   = 0;
        while (cnt < n && k < 4 * n + 20) begin
            bus.s_valid  = pat[k % len];
            s_data       = {tile, 10'(cnt)};
            bus.start    = (k == poke);
            bus.cfg_rows = 10'd7;
            #1;
            chk("fill_s_ready", 32'(bus.s_ready), 1);
            chk("fill_m_valid", 32'(bus.m_valid), 0);
            chk("fill_we",      32'(bus.we),      32'(bus.s_valid));
            if (bus.we) chk("fill_wr_addr", 32'(bus.wr_addr), 32'(cnt));
            if (bus.s_valid) cnt++;
            k++;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.start   = 1'b0;
        chk("fill_count", 32'(cnt), 32'(n));
        #1;
        chk("fill_exit_s_ready", 32'(bus.s_ready), 0);
        chk("fill_exit_busy",    32'(bus.busy),    1);
    endtask

    task automatic drain(input int n, input logic [7:0] pat, input int len,
                         input int poke, input int abort, input logic [5:0] tile,
                         output int steps);
        int  hs         = 0;
        int  k          = 0;
        logic prev_stall = 1'b0;
        while (hs < n && k < 4 * n + 40) begin
            bus.m_ready  = pat[k % len];
            bus.start    = (k == poke);
            bus.cfg_rows = 10'd7;
            #1;
            if (k == 0) begin
                chk("drain_first_m_valid", 32'(bus.m_valid), 0);
                chk("drain_first_rd_addr", 32'(bus.rd_addr), 0);
            end
            if (prev_stall) chk("drain_hold_valid", 32'(bus.m_valid), 1);
            if (bus.m_valid) begin
                chk("drain_data",   32'(ram_q),       32'({tile, 10'(hs)}));
                chk("drain_m_last", 32'(bus.m_last),  32'(hs == n - 1));
                if (!bus.m_ready) chk("drain_stall_rd", 32'(bus.rd_addr), 32'(hs));
            end else begin
                chk("drain_m_last_idle", 32'(bus.m_last), 0);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            if (bus.m_valid && bus.m_ready) hs++;
            k++;
            if (abort > 0 && hs == abort) begin
                @(negedge clk);
                bus.start = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                chk_all_zero("async_rst");
                steps = k;
                return;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        steps = k;
        chk("drain_count", 32'(hs), 32'(n));
        #1;
        chk("done_pulse",      32'(bus.done),    1);
        chk("done_busy",       32'(bus.busy),    0);
        chk("done_m_valid",    32'(bus.m_valid), 0);
        @(negedge clk);
        #1;
        chk("done_clear",      32'(bus.done),    0);
        chk("post_tile_busy",  32'(bus.busy),    0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.cfg_rows = '0;
        bus.s_valid  = 1'b0;
        bus.m_ready  = 1'b1;
        s_data       = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic tile, full throughput.
        do_start(4);
        chk("basic_busy", 32'(bus.busy), 1);
        fill(4, 8'hFF, 8, -1, 6'd1);
        drain(4, 8'hFF, 8, -1, -1, 6'd1, steps);
        chk("basic_throughput", 32'(steps), 5);

        // Bursty input.
        do_start(5);
        fill(5, 8'b1100_1101, 8, -1, 6'd2);
        drain(5, 8'hFF, 8, -1, -1, 6'd2, steps);

        // Backpressure: 1,0,0,1,0,1,1 repeating.
        do_start(6);
        fill(6, 8'hFF, 8, -1, 6'd3);
        drain(6, 8'b1110_1001, 7, -1, -1, 6'd3, steps);

        // Single row.
        do_start(1);
        fill(1, 8'hFF, 8, -1, 6'd4);
        drain(1, 8'hFF, 8, -1, -1, 6'd4, steps);

        // Illegal counts.
        do_start(0);
        chk("cfg0_err",  32'(bus.cfg_err), 1);
        chk("cfg0_busy", 32'(bus.busy),    0);
        bus.s_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("cfg0_err_clear", 32'(bus.cfg_err), 0);
        chk("cfg0_we",        32'(bus.we),      0);
        chk("cfg0_idle",      32'(bus.busy),    0);
        bus.s_valid = 1'b0;
        do_start(544);
        chk("cfg544_err",  32'(bus.cfg_err), 1);
        chk("cfg544_busy", 32'(bus.busy),    0);
        bus.s_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("cfg544_err_clear", 32'(bus.cfg_err), 0);
        chk("cfg544_we",        32'(bus.we),      0);
        chk("cfg544_idle",      32'(bus.busy),    0);
        bus.s_valid = 1'b0;

        // Start pulses during FILL and DRAIN are ignored.
        do_start(3);
        fill(3, 8'hFF, 8, 1, 6'd5);
        drain(3, 8'hFF, 8, 2, -1, 6'd5, steps);

        // Full-depth tile.
        do_start(543);
        fill(543, 8'hFF, 8, -1, 6'd6);
        drain(543, 8'hFF, 8, -1, -1, 6'd6, steps);
        chk("full_throughput", 32'(steps), 544);

        // Reset after 3 of 8 rows drained, then a fresh tile.
        do_start(8);
        fill(8, 8'hFF, 8, -1, 6'd7);
        drain(8, 8'hFF, 8, -1, 3, 6'd7, steps);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_hold_done", 32'(bus.done), 0);
            chk("rst_hold_busy", 32'(bus.busy), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_done", 32'(bus.done), 0);
        do_start(2);
        fill(2, 8'hFF, 8, -1, 6'd8);
        drain(2, 8'hFF, 8, -1, -1, 6'd8, steps);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_buffer_ctrl.md
Name: systolic_buffer_ctrl

Overview:
Sequencer for the systolic-array output buffer, a 1R1W synchronous RAM with 1-cycle read latency. In each tile it first fills the buffer with cfg_rows result rows streamed from the array, writing to incrementing addresses. It then drains the same rows in order to the downstream consumer under a valid/ready handshake, holding data stable under backpressure. The row data path runs array -> buffer in_data and buffer out_data -> consumer; this block drives only control and addresses.

Parameters:
DEPTH, 543, buffer rows (512 data + 31 skew zeros); maximum legal cfg_rows.
ADDR_WIDTH, 10, buffer address width; must satisfy 2^ADDR_WIDTH >= DEPTH.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  tile start pulse; sampled only in IDLE
cfg_rows  in  ADDR_WIDTH  rows per tile; sampled with start
s_valid  in  1  array presents a result row
s_ready  out  1  controller accepts a row (FILL state)
we  out  1  buffer write enable
wr_addr  out  ADDR_WIDTH  buffer write address
rd_addr  out  ADDR_WIDTH  buffer read address
m_valid  out  1  buffer out_data holds a valid row
m_ready  in  1  consumer accepts the row
m_last  out  1  current m_valid row is the last of the tile
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at tile completion
cfg_err  out  1  one-cycle pulse: illegal cfg_rows at start

Behaviour:
- Reset (async assert, sync release): state=IDLE. s_ready, we, m_valid, m_last, busy, done and cfg_err are 0; wr_addr and rd_addr are 0. All pointers and counters clear. Reset mid-tile abandons the tile with no done pulse; buffer contents are don't-care.
- States: IDLE, FILL, DRAIN.
- IDLE: on start, latch cfg_rows.
  - If cfg_rows==0 or cfg_rows>DEPTH: pulse cfg_err next cycle and stay in IDLE.
  - Otherwise go to FILL. start in any other state is ignored.
- FILL:
  - s_ready=1; we = s_valid & s_ready (combinational); wr_addr = wr_ptr (register, starts at 0).
  - Each write increments wr_ptr.
  - The write that brings the count to cfg_rows moves the state to DRAIN on the same edge. s_ready=0 from the next cycle.
- DRAIN, 1-cycle RAM latency:
  - issue_ptr starts at 0; disp_addr holds the address of the row currently shown.
  - stall = m_valid & ~m_ready.
  - rd_addr (combinational) = stall ? disp_addr : issue_ptr. While stalled the RAM re-reads the same row, so out_data stays stable.
  - A read is issued when ~stall and issue_ptr < cfg_rows. Next cycle m_valid=1, disp_addr=that address, and issue_ptr increments.
  - When not stalled and nothing is left to issue, m_valid clears after the handshake.
  - First DRAIN cycle issues addr 0; m_valid=1 the following cycle. With m_ready held high, throughput is 1 row/cycle.
  - m_last = m_valid & (disp_addr == cfg_rows-1).
  - The handshake on the m_last row returns the state to IDLE and pulses done in the next cycle; busy is low in that cycle.
- No read and write to the same address in the same cycle, because FILL and DRAIN are exclusive. m_valid is never asserted in FILL or IDLE.
- m_valid, once asserted, is not withdrawn until m_ready (AXI-stream rule).
- Width: counters are ADDR_WIDTH+1 bits so cfg_rows=DEPTH compares correctly. Addresses never exceed DEPTH-1.

Test Plan:
- Basic tile: start, cfg_rows=4, s_valid continuously high, m_ready=1 -> writes at addr 0..3 on 4 consecutive cycles. Rows then appear on m_valid in order 0..3 on 4 consecutive cycles, m_last on row 3, done exactly one cycle after the row-3 handshake, busy low afterwards.
- Bursty input: cfg_rows=5, s_valid toggling 1,0,1,1,0,0,1,1 -> exactly 5 writes to addresses 0..4, with we only when s_valid=1. Transition to DRAIN happens right after the 5th write.
- Backpressure: cfg_rows=6, m_ready pattern 1,0,0,1,0,1,1,... -> each row is held stable with rd_addr = disp_addr while stalled. No row is skipped or duplicated; consumer receives 0..5 in order.
- Boundaries: cfg_rows=1 -> single write at 0, single output with m_last=1. cfg_rows=543 -> last write at addr 542, m_last on addr 542. cfg_rows=0 and cfg_rows=544 -> cfg_err pulse, no we, state stays IDLE.
- Ignored start: pulse start during FILL and during DRAIN with a different cfg_rows -> no effect; the tile completes with the original count.
- Reset mid-DRAIN: assert rst_n=0 after 3 of 8 rows are drained -> all outputs go to 0 immediately (asynchronous), no done pulse. A new start with cfg_rows=2 afterwards completes normally.
